// File: rtl/warp_fetch_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module      : warp_fetch_scheduler_if
// Description : Launch, fetch, decoder-feedback and status bundle of the
//               warp fetch scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
interface warp_fetch_scheduler_if #(
    parameter int PcWidth   = 32,
    parameter int NumWarps  = 8,
    parameter int WarpWidth = 32
);
    localparam int WidWidth = (NumWarps > 1) ? $clog2(NumWarps) : 1;

    logic                 launch_valid_i;
    logic                 launch_ready_o;
    logic [PcWidth-1:0]   launch_pc_i;
    logic [WarpWidth-1:0] launch_act_mask_i;
    logic [WidWidth-1:0]  launch_warp_id_o;

    logic                 ic_ready_i;
    logic                 fe_valid_o;
    logic [PcWidth-1:0]   fe_pc_o;
    logic [WarpWidth-1:0] fe_act_mask_o;
    logic [WidWidth-1:0]  fe_warp_id_o;

    logic                 dec_decoded_i;
    logic                 dec_stop_warp_i;
    logic [WidWidth-1:0]  dec_decoded_warp_id_i;
    logic [PcWidth-1:0]   dec_decoded_next_pc_i;

    logic [NumWarps-1:0]  warp_active_o;
    logic                 all_idle_o;

    // Scheduler side
    modport slave (
        input  launch_valid_i, launch_pc_i, launch_act_mask_i,
        input  ic_ready_i,
        input  dec_decoded_i, dec_stop_warp_i, dec_decoded_warp_id_i, dec_decoded_next_pc_i,
        output launch_ready_o, launch_warp_id_o,
        output fe_valid_o, fe_pc_o, fe_act_mask_o, fe_warp_id_o,
        output warp_active_o, all_idle_o
    );

    // Dispatcher / icache / decoder side
    modport master (
        output launch_valid_i, launch_pc_i, launch_act_mask_i,
        output ic_ready_i,
        output dec_decoded_i, dec_stop_warp_i, dec_decoded_warp_id_i, dec_decoded_next_pc_i,
        input  launch_ready_o, launch_warp_id_o,
        input  fe_valid_o, fe_pc_o, fe_act_mask_o, fe_warp_id_o,
        input  warp_active_o, all_idle_o
    );
endinterface
`default_nettype wire

// File: rtl/warp_fetch_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : warp_fetch_scheduler
// Description : Per-CU warp fetch controller: launch into lowest idle slot,
//               round-robin fetch arbitration, decoder feedback loop.
// Revision    : 1.0 - initial release
// ============================================================================
module warp_fetch_scheduler #(
    parameter int PcWidth   = 32,
    parameter int NumWarps  = 8,
    parameter int WarpWidth = 32
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    warp_fetch_scheduler_if.slave  bus
);
    localparam int WidWidth = (NumWarps > 1) ? $clog2(NumWarps) : 1;

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_READY = 2'd1;
    localparam logic [1:0] c_ST_WAIT  = 2'd2;

    logic [1:0]           r_state   [NumWarps];
    logic [PcWidth-1:0]   r_pc      [NumWarps];
    logic [WarpWidth-1:0] r_mask    [NumWarps];
    logic [WidWidth-1:0]  r_ptr;
    logic                 r_lock;
    logic [WidWidth-1:0]  r_lock_id;

    logic [1:0]           w_state_nxt [NumWarps];
    logic [PcWidth-1:0]   w_pc_nxt    [NumWarps];
    logic [WarpWidth-1:0] w_mask_nxt  [NumWarps];
    logic [WidWidth-1:0]  w_ptr_nxt;
    logic                 w_lock_nxt;
    logic [WidWidth-1:0]  w_lock_id_nxt;

    logic                 w_any_idle;
    logic [WidWidth-1:0]  w_launch_id;
    logic                 w_launch;
    logic                 w_rr_found;
    logic [WidWidth-1:0]  w_rr_id;
    logic [WidWidth-1:0]  w_grant_id;
    logic                 w_fe_valid;
    logic                 w_handshake;
    logic [NumWarps-1:0]  w_active;

    // Lowest idle slot: scan downwards so the last hit is the smallest index
    always_comb begin
        w_any_idle  = 1'b0;
        w_launch_id = '0;
        for (int i = NumWarps - 1; i >= 0; i--) begin
            if (r_state[i] == c_ST_IDLE) begin
                w_any_idle  = 1'b1;
                w_launch_id = WidWidth'(i);
            end
        end
    end

    // First ready warp at or after the pointer, with the offset reduced by a
    // single subtract so non-power-of-two warp counts never overflow the range
    always_comb begin
        int w_idx;
        w_idx      = 0;
        w_rr_found = 1'b0;
        w_rr_id    = '0;
        for (int k = NumWarps - 1; k >= 0; k--) begin
            w_idx = int'(r_ptr) + k;
            if (w_idx >= NumWarps) begin
                w_idx = w_idx - NumWarps;
            end
            if (r_state[w_idx] == c_ST_READY) begin
                w_rr_found = 1'b1;
                w_rr_id    = WidWidth'(w_idx);
            end
        end
    end

    assign w_launch    = bus.launch_valid_i && w_any_idle;
    assign w_fe_valid  = w_rr_found || r_lock;
    assign w_grant_id  = r_lock ? r_lock_id : w_rr_id;
    assign w_handshake = w_fe_valid && bus.ic_ready_i;

    always_comb begin
        w_ptr_nxt     = r_ptr;
        w_lock_nxt    = r_lock;
        w_lock_id_nxt = r_lock_id;
        if (w_handshake) begin
            w_lock_nxt = 1'b0;
            w_ptr_nxt  = (int'(w_grant_id) == NumWarps - 1) ? '0 : w_grant_id + 1'b1;
        end else if (w_fe_valid) begin
            w_lock_nxt    = 1'b1;
            w_lock_id_nxt = w_grant_id;
        end

        // Launch, fetch and decode each act on a different state, so they can
        // be applied independently without ever colliding on one warp
        for (int i = 0; i < NumWarps; i++) begin
            w_state_nxt[i] = r_state[i];
            w_pc_nxt[i]    = r_pc[i];
            w_mask_nxt[i]  = r_mask[i];
            if (w_launch && (int'(w_launch_id) == i)) begin
                w_state_nxt[i] = c_ST_READY;
                w_pc_nxt[i]    = bus.launch_pc_i;
                w_mask_nxt[i]  = bus.launch_act_mask_i;
            end
            if (w_handshake && (int'(w_grant_id) == i)) begin
                w_state_nxt[i] = c_ST_WAIT;
            end
            if (bus.dec_decoded_i && (int'(bus.dec_decoded_warp_id_i) == i) &&
                (r_state[i] == c_ST_WAIT)) begin
                if (bus.dec_stop_warp_i) begin
                    w_state_nxt[i] = c_ST_IDLE;
                end else begin
                    w_state_nxt[i] = c_ST_READY;
                    w_pc_nxt[i]    = bus.dec_decoded_next_pc_i;
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NumWarps; i++) begin
                r_state[i] <= c_ST_IDLE;
                r_pc[i]    <= '0;
                r_mask[i]  <= '0;
            end
            r_ptr     <= '0;
            r_lock    <= 1'b0;
            r_lock_id <= '0;
        end else begin
            for (int i = 0; i < NumWarps; i++) begin
                r_state[i] <= w_state_nxt[i];
                r_pc[i]    <= w_pc_nxt[i];
                r_mask[i]  <= w_mask_nxt[i];
            end
            r_ptr     <= w_ptr_nxt;
            r_lock    <= w_lock_nxt;
            r_lock_id <= w_lock_id_nxt;
        end
    end

    always_comb begin
        w_active = '0;
        for (int i = 0; i < NumWarps; i++) begin
            w_active[i] = (r_state[i] != c_ST_IDLE);
        end
    end

    assign bus.launch_ready_o   = w_any_idle;
    assign bus.launch_warp_id_o = w_launch_id;
    assign bus.fe_valid_o       = w_fe_valid;
    assign bus.fe_warp_id_o     = w_fe_valid ? w_grant_id : '0;
    assign bus.fe_pc_o          = w_fe_valid ? r_pc[w_grant_id] : '0;
    assign bus.fe_act_mask_o    = w_fe_valid ? r_mask[w_grant_id] : '0;
    assign bus.warp_active_o    = w_active;
    assign bus.all_idle_o       = ~|w_active;

`ifndef SYNTHESIS
    a_launch_hold : assert property (@(posedge clk_i) disable iff (!rst_ni)
        (bus.launch_valid_i && !bus.launch_ready_o) |=> bus.launch_valid_i);

    a_fe_stable : assert property (@(posedge clk_i) disable iff (!rst_ni)
        (bus.fe_valid_o && !bus.ic_ready_i) |=>
        (bus.fe_valid_o && $stable(bus.fe_pc_o) && $stable(bus.fe_act_mask_o) &&
         $stable(bus.fe_warp_id_o)));

    a_dec_wait : assert property (@(posedge clk_i) disable iff (!rst_ni)
        bus.dec_decoded_i |-> (r_state[bus.dec_decoded_warp_id_i] == c_ST_WAIT));
`endif

endmodule
`default_nettype wire

// File: tb/tb_warp_fetch_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_warp_fetch_scheduler
// Description : Self-checking bench for warp_fetch_scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_warp_fetch_scheduler;
    localparam int NW = 8;

    logic clk = 1'b0;
    logic rst_n;

    warp_fetch_scheduler_if #(.PcWidth(32), .NumWarps(NW), .WarpWidth(32)) bus ();

    warp_fetch_scheduler #(.PcWidth(32), .NumWarps(NW), .WarpWidth(32)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    // Reference model: warp status plus the fetch bookkeeping the rules imply
    typedef enum {M_IDLE, M_READY, M_WAIT} mst_e;
    mst_e        m_st   [NW];
    logic [31:0] m_pc   [NW];
    logic [31:0] m_mask [NW];
    int          m_ptr;
    bit          m_lock;
    int          m_lock_id;
    bit          hs_valid;
    int          hs_id;

    typedef struct packed {
        logic        lv;
        logic [31:0] lpc;
        logic        icr;
        logic        dd;
        logic        dstop;
        logic [2:0]  did;
        logic [31:0] dnpc;
        logic        e_fev;
        logic [31:0] e_pc;
        logic [2:0]  e_id;
        logic        e_lr;
        logic [2:0]  e_lid;
        logic        e_idle;
    } vec_t;
    vec_t tbl [6];

    int exp_ord [6] = '{0, 1, 2, 0, 1, 2};
    int pcs     [3] = '{32'h10, 32'h20, 32'h30};

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int m_grant();
        if (m_lock) return m_lock_id;
        for (int k = 0; k < NW; k++) begin
            if (m_st[(m_ptr + k) % NW] == M_READY) return (m_ptr + k) % NW;
        end
        return -1;
    endfunction

    function automatic int m_lowest_idle();
        for (int i = 0; i < NW; i++) if (m_st[i] == M_IDLE) return i;
        return -1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NW; i++) begin
            m_st[i] = M_IDLE; m_pc[i] = '0; m_mask[i] = '0;
        end
        m_ptr = 0; m_lock = 0; m_lock_id = 0; hs_valid = 0; hs_id = 0;
    endtask

    task automatic model_update();
        int   g, li;
        mst_e old [NW];
        g  = m_grant();
        li = m_lowest_idle();
        for (int i = 0; i < NW; i++) old[i] = m_st[i];
        hs_valid = 0;
        if (bus.launch_valid_i && li >= 0) begin
            m_st[li] = M_READY; m_pc[li] = bus.launch_pc_i; m_mask[li] = bus.launch_act_mask_i;
        end
        if (g >= 0) begin
            if (bus.ic_ready_i) begin
                m_st[g] = M_WAIT; m_ptr = (g + 1) % NW; m_lock = 0;
                hs_valid = 1; hs_id = g;
            end else begin
                m_lock = 1; m_lock_id = g;
            end
        end
        if (bus.dec_decoded_i && old[bus.dec_decoded_warp_id_i] == M_WAIT) begin
            if (bus.dec_stop_warp_i) m_st[bus.dec_decoded_warp_id_i] = M_IDLE;
            else begin
                m_st[bus.dec_decoded_warp_id_i] = M_READY;
                m_pc[bus.dec_decoded_warp_id_i] = bus.dec_decoded_next_pc_i;
            end
        end
    endtask

    task automatic check_all();
        int          g, li;
        logic [NW-1:0] act;
        g  = m_grant();
        li = m_lowest_idle();
        chk("fe_valid", bus.fe_valid_o, (g >= 0));
        if (g >= 0) begin
            chk("fe_warp_id", bus.fe_warp_id_o, g);
            chk("fe_pc", bus.fe_pc_o, m_pc[g]);
            chk("fe_act_mask", bus.fe_act_mask_o, m_mask[g]);
        end
        chk("launch_ready", bus.launch_ready_o, (li >= 0));
        if (li >= 0) chk("launch_warp_id", bus.launch_warp_id_o, li);
        act = '0;
        for (int i = 0; i < NW; i++) act[i] = (m_st[i] != M_IDLE);
        chk("warp_active", bus.warp_active_o, act);
        chk("all_idle", bus.all_idle_o, (act == '0));
    endtask

    task automatic clear_inputs();
        bus.launch_valid_i        = 1'b0;
        bus.launch_pc_i           = '0;
        bus.launch_act_mask_i     = '0;
        bus.ic_ready_i            = 1'b0;
        bus.dec_decoded_i         = 1'b0;
        bus.dec_stop_warp_i       = 1'b0;
        bus.dec_decoded_warp_id_i = '0;
        bus.dec_decoded_next_pc_i = '0;
    endtask

    task automatic step();
        model_update();
        @(posedge clk);
        @(negedge clk);
        check_all();
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        check_all();
    endtask

    task automatic launch(logic [31:0] pc, logic [31:0] mask, logic icr);
        clear_inputs();
        bus.launch_valid_i    = 1'b1;
        bus.launch_pc_i       = pc;
        bus.launch_act_mask_i = mask;
        bus.ic_ready_i        = icr;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int  got [$];
        int  wid [$];
        bit  pend, lr_pre, found;

        // lv, lpc, icr, dd, stop, did, dnpc | fev, pc, id, lr, lid, idle
        tbl[0] = '{1'b1, 32'h100, 1'b1, 1'b0, 1'b0, 3'd0, 32'h0,   1'b1, 32'h100, 3'd0, 1'b1, 3'd1, 1'b0};
        tbl[1] = '{1'b0, 32'h0,   1'b1, 1'b0, 1'b0, 3'd0, 32'h0,   1'b0, 32'h0,   3'd0, 1'b1, 3'd1, 1'b0};
        tbl[2] = '{1'b0, 32'h0,   1'b1, 1'b1, 1'b0, 3'd0, 32'h101, 1'b1, 32'h101, 3'd0, 1'b1, 3'd1, 1'b0};
        tbl[3] = '{1'b0, 32'h0,   1'b1, 1'b0, 1'b0, 3'd0, 32'h0,   1'b0, 32'h0,   3'd0, 1'b1, 3'd1, 1'b0};
        tbl[4] = '{1'b0, 32'h0,   1'b1, 1'b1, 1'b1, 3'd0, 32'h0,   1'b0, 32'h0,   3'd0, 1'b1, 3'd0, 1'b1};
        tbl[5] = '{1'b0, 32'h0,   1'b0, 1'b0, 1'b0, 3'd0, 32'h0,   1'b0, 32'h0,   3'd0, 1'b1, 3'd0, 1'b1};

        // Reset state, then the basic launch / fetch / feedback table
        clear_inputs();
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        chk("rst_fe_valid", bus.fe_valid_o, 0);
        chk("rst_launch_ready", bus.launch_ready_o, 1);
        chk("rst_warp_active", bus.warp_active_o, 0);
        chk("rst_all_idle", bus.all_idle_o, 1);
        chk("rst_fe_pc", bus.fe_pc_o, 0);
        chk("rst_fe_mask", bus.fe_act_mask_o, 0);
        chk("rst_fe_id", bus.fe_warp_id_o, 0);
        chk("rst_launch_id", bus.launch_warp_id_o, 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++) begin
            clear_inputs();
            bus.launch_valid_i        = tbl[i].lv;
            bus.launch_pc_i           = tbl[i].lpc;
            bus.launch_act_mask_i     = 32'hFFFF_FFFF;
            bus.ic_ready_i            = tbl[i].icr;
            bus.dec_decoded_i         = tbl[i].dd;
            bus.dec_stop_warp_i       = tbl[i].dstop;
            bus.dec_decoded_warp_id_i = tbl[i].did;
            bus.dec_decoded_next_pc_i = tbl[i].dnpc;
            step();
            chk("tbl_fe_valid", bus.fe_valid_o, tbl[i].e_fev);
            if (tbl[i].e_fev) begin
                chk("tbl_fe_pc", bus.fe_pc_o, tbl[i].e_pc);
                chk("tbl_fe_id", bus.fe_warp_id_o, tbl[i].e_id);
                chk("tbl_fe_mask", bus.fe_act_mask_o, 32'hFFFF_FFFF);
            end
            chk("tbl_launch_ready", bus.launch_ready_o, tbl[i].e_lr);
            if (tbl[i].e_lr) chk("tbl_launch_id", bus.launch_warp_id_o, tbl[i].e_lid);
            chk("tbl_all_idle", bus.all_idle_o, tbl[i].e_idle);
        end

        // Round-robin with immediate decoder feedback
        do_reset();
        for (int c = 0; c < 9; c++) begin
            clear_inputs();
            bus.ic_ready_i = 1'b1;
            if (c < 3) launch(pcs[c], 32'hFFFF_FFFF, 1'b1);
            if (hs_valid) begin
                bus.dec_decoded_i         = 1'b1;
                bus.dec_decoded_warp_id_i = 3'(hs_id);
                bus.dec_decoded_next_pc_i = m_pc[hs_id] + 32'd1;
            end
            if (bus.fe_valid_o) got.push_back(int'(bus.fe_warp_id_o));
            step();
        end
        for (int i = 0; i < 6; i++) begin
            if (i < got.size()) chk("rr_order", got[i], exp_ord[i]);
            else chk("rr_order_missing", 0, 1);
        end

        // Lock holds the grant even when a warp nearer the pointer turns ready
        do_reset();
        launch(32'h40, 32'hF0F0, 1'b0); step();
        clear_inputs(); bus.ic_ready_i = 1'b1; step();
        clear_inputs();
        bus.dec_decoded_i = 1'b1; bus.dec_decoded_warp_id_i = 3'd0; bus.dec_decoded_next_pc_i = 32'h44;
        step();
        launch(32'h80, 32'h1, 1'b0); step();
        for (int c = 0; c < 5; c++) begin
            chk("lock_id", bus.fe_warp_id_o, 0);
            chk("lock_pc", bus.fe_pc_o, 32'h44);
            clear_inputs(); step();
        end
        clear_inputs(); bus.ic_ready_i = 1'b1;
        chk("lock_release_id", bus.fe_warp_id_o, 0);
        step();
        chk("after_lock_id", bus.fe_warp_id_o, 1);
        chk("after_lock_pc", bus.fe_pc_o, 32'h80);

        // Fill every slot, then free warp 5
        do_reset();
        for (int i = 0; i < NW; i++) begin
            launch(32'h1000 + 32'(i * 16), $urandom, 1'b1);
            chk("full_launch_id", bus.launch_warp_id_o, i);
            step();
        end
        chk("full_launch_ready", bus.launch_ready_o, 0);
        found = 0;
        for (int c = 0; c < 20 && !found; c++) begin
            if (m_st[5] == M_WAIT) found = 1;
            else begin clear_inputs(); bus.ic_ready_i = 1'b1; step(); end
        end
        if (!found) begin
            n_vec++; n_bad++;
            $display("FAIL warp5_wait_timeout: got 0 expected 1");
        end else begin
            clear_inputs();
            bus.dec_decoded_i = 1'b1; bus.dec_stop_warp_i = 1'b1; bus.dec_decoded_warp_id_i = 3'd5;
            step();
            chk("freed_launch_ready", bus.launch_ready_o, 1);
            chk("freed_launch_id", bus.launch_warp_id_o, 5);
        end

        // Asynchronous reset with a warp in WAIT and the lock set
        do_reset();
        launch(32'h200, 32'hFF, 1'b1); step();
        launch(32'h300, 32'hFF, 1'b1); step();
        clear_inputs(); step();
        chk("pre_rst_fe_valid", bus.fe_valid_o, 1);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("async_fe_valid", bus.fe_valid_o, 0);
        chk("async_all_idle", bus.all_idle_o, 1);
        chk("async_warp_active", bus.warp_active_o, 0);
        chk("async_launch_ready", bus.launch_ready_o, 1);
        @(negedge clk);
        rst_n = 1'b1;
        chk("post_rst_launch_id", bus.launch_warp_id_o, 0);
        launch(32'h500, 32'h3, 1'b1); step();
        chk("post_rst_fe_id", bus.fe_warp_id_o, 0);
        chk("post_rst_fe_pc", bus.fe_pc_o, 32'h500);

        // Randomised traffic against the reference model
        do_reset();
        pend = 0;
        for (int c = 0; c < 3000; c++) begin
            if (!pend) begin
                bus.launch_valid_i    = ($urandom_range(0, 3) == 0);
                bus.launch_pc_i       = $urandom;
                bus.launch_act_mask_i = $urandom;
            end
            bus.ic_ready_i            = ($urandom_range(0, 9) < 7);
            bus.dec_decoded_i         = 1'b0;
            bus.dec_stop_warp_i       = 1'($urandom);
            bus.dec_decoded_warp_id_i = 3'($urandom);
            bus.dec_decoded_next_pc_i = $urandom;
            wid.delete();
            for (int i = 0; i < NW; i++) if (m_st[i] == M_WAIT) wid.push_back(i);
            if (wid.size() > 0 && $urandom_range(0, 2) != 0) begin
                bus.dec_decoded_i         = 1'b1;
                bus.dec_decoded_warp_id_i = 3'(wid[$urandom_range(0, wid.size() - 1)]);
                bus.dec_stop_warp_i       = ($urandom_range(0, 3) == 0);
            end
            lr_pre = bus.launch_ready_o;
            step();
            pend = bus.launch_valid_i && !lr_pre;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/warp_fetch_scheduler.md
Name: warp_fetch_scheduler

Overview:
Per-compute-unit fetch controller. Tracks the PC and active mask of every warp, and arbitrates round-robin among fetch-ready warps to issue one instruction-fetch request per cycle to the instruction cache. It closes the loop with the decoder through the decoded/next-PC/stop feedback. Warps are launched by the upstream dispatcher into the lowest-index idle slot.

Parameters:
- PcWidth, 32, width of program counter
- NumWarps, 8, warps per compute unit
- WarpWidth, 32, threads per warp (active-mask width)
- WidWidth, NumWarps>1 ? $clog2(NumWarps) : 1, derived, do not override

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- launch_valid_i  in  1  request to start a warp
- launch_ready_o  out  1  at least one warp slot is IDLE
- launch_pc_i  in  PcWidth  start PC
- launch_act_mask_i  in  WarpWidth  initial active mask
- launch_warp_id_o  out  WidWidth  slot that will be used (lowest IDLE index)
- ic_ready_i  in  1  instruction cache accepts fetch
- fe_valid_o  out  1  fetch request valid
- fe_pc_o  out  PcWidth  fetch PC
- fe_act_mask_o  out  WarpWidth  fetch active mask
- fe_warp_id_o  out  WidWidth  fetching warp
- dec_decoded_i  in  1  decoder finished an instruction
- dec_stop_warp_i  in  1  decoded instruction terminates the warp
- dec_decoded_warp_id_i  in  WidWidth  warp of decoded instruction
- dec_decoded_next_pc_i  in  PcWidth  next PC for that warp
- warp_active_o  out  NumWarps  per-warp "not IDLE"
- all_idle_o  out  1  every warp IDLE

Behaviour:
- Per-warp state: IDLE, READY, WAIT. Per-warp registers: pc, act_mask.
- Reset (async, rst_ni=0): all warps IDLE; pc and act_mask cleared to 0; round-robin pointer 0; lock flag 0. Resulting outputs: fe_valid_o=0, launch_ready_o=1, warp_active_o=0, all_idle_o=1, fe_* data=0, launch_warp_id_o=0. Reset mid-operation discards all in-flight state.
- Launch: launch_ready_o = any IDLE, computed from registered state only. launch_warp_id_o = lowest IDLE index.
  - On launch_valid_i && launch_ready_o, that slot goes IDLE->READY with pc=launch_pc_i and act_mask=launch_act_mask_i.
  - The slot is visible to arbitration the next cycle, so the earliest fe_valid_o is t+1.
- Arbitration:
  - fe_valid_o = any READY, or lock set.
  - Grant is the first READY warp at index >= pointer, wrapping modulo NumWarps.
  - fe_pc_o, fe_act_mask_o and fe_warp_id_o come from the granted warp.
- Stability: if fe_valid_o && !ic_ready_i, set lock and hold the granted id. Outputs stay unchanged until the handshake completes, even if other warps become READY. Lock clears on handshake.
- Fetch handshake (fe_valid_o && ic_ready_i): the granted warp goes READY->WAIT, and pointer = granted+1 (wrap to 0 after NumWarps-1). This gives one outstanding fetch per warp.
- Decoder feedback on dec_decoded_i, for warp w = dec_decoded_warp_id_i:
  - If w is in WAIT and dec_stop_warp_i=0: WAIT->READY, pc <= dec_decoded_next_pc_i. The warp can be re-fetched the next cycle.
  - If w is in WAIT and dec_stop_warp_i=1: WAIT->IDLE. The slot can be launched the next cycle (not the same cycle).
  - If w is not in WAIT: the event is ignored and the non-synthesis assertion fires.
- Simultaneous events in one cycle (launch, fetch handshake, decode feedback) can never target the same warp, because each applies to a different state. All three are applied in parallel.
- Arithmetic: the pointer wraps modulo NumWarps. For non-power-of-two NumWarps, values >= NumWarps are never produced. The PC is taken verbatim from the decoder; no increment is done here.
- warp_active_o[i] = state[i] != IDLE. all_idle_o = ~|warp_active_o.
- Non-synthesis assertions:
  - launch_valid_i must not drop without a handshake.
  - fe_* must stay stable while valid && !ready.
  - No decode feedback for a non-WAIT warp.

Test Plan:
- Reset, then launch pc=0x100, mask=0xFFFFFFFF with ic_ready_i=1 → launch_warp_id_o=0. Next cycle: fe_valid_o=1, fe_pc_o=0x100, fe_warp_id_o=0. Following cycle: fe_valid_o=0 (warp 0 in WAIT).
- Decode feedback warp 0, next_pc=0x101, stop=0 → next cycle fe_pc_o=0x101. Then feedback with stop=1 → warp_active_o=0 and all_idle_o=1 next cycle.
- Launch warps 0,1,2 (pcs 0x10, 0x20, 0x30) with immediate decode feedback each cycle → grant order 0,1,2,0,1,2. No warp is granted twice in a row while others are READY.
- Hold ic_ready_i=0 for 5 cycles while a new warp launches → fe_warp_id_o and fe_pc_o unchanged, with the lock held. Release → handshake for the original warp, pointer advances.
- Launch all 8 warps → launch_ready_o=0. Stop warp 5 → launch_ready_o=1 the next cycle and launch_warp_id_o=5.
- Assert rst_ni low while warps are in WAIT and the lock is set → fe_valid_o=0 and all_idle_o=1 immediately (asynchronous). After release, the first launch gets id 0.
